// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input, RAM write port and CPU control bundle of the program loader
interface prog_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        ram_w_en;
    logic [7:0]  ram_w_addr;
    logic [15:0] ram_w_data;
    logic        bus_own;
    logic        cpu_rst_n;
    logic [7:0]  start_pc;
    logic        err;

    modport master (
        output in_valid, in_data,
        input  in_ready, ram_w_en, ram_w_addr, ram_w_data, bus_own, cpu_rst_n, start_pc, err
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ram_w_en, ram_w_addr, ram_w_data, bus_own, cpu_rst_n, start_pc, err
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: loads a framed byte-stream program into RAM, holding the CPU in reset until done
module prog_loader #(
    parameter bit CHECKSUM_EN = 1'b1
) (
    input logic       clk,
    input logic       rst,
    prog_loader_if.slave bus
);
    typedef enum logic [2:0] {S_ADDR, S_CNT, S_HI, S_LO, S_CSUM, S_RUN, S_ERR} state_t;

    state_t     state, next_state;
    logic [7:0] ptr, remaining, hi, sum;
    logic       accept;

    assign accept = bus.in_valid & bus.in_ready;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_ADDR;
        else     state <= next_state;
    end

    // next state: only an accepted byte moves the frame parser
    always_comb begin
        next_state = state;
        if (accept) begin
            case (state)
                S_ADDR:  next_state = S_CNT;
                S_CNT:   next_state = (bus.in_data != 8'd0) ? S_HI : (CHECKSUM_EN ? S_CSUM : S_RUN);
                S_HI:    next_state = S_LO;
                S_LO:    next_state = (remaining > 8'd1) ? S_HI : (CHECKSUM_EN ? S_CSUM : S_RUN);
                S_CSUM:  next_state = (bus.in_data == sum) ? S_RUN : S_ERR;
                default: next_state = state;
            endcase
        end
    end

    // state-decoded outputs: ready in all parsing states, bus released only in RUN
    always_comb begin
        bus.in_ready = (state != S_RUN) && (state != S_ERR);
        bus.bus_own  = (state != S_RUN);
    end

    // datapath: address/count/sum tracking and the registered RAM write strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ram_w_en   <= 1'b0;
            bus.ram_w_addr <= 8'd0;
            bus.ram_w_data <= 16'd0;
            bus.cpu_rst_n  <= 1'b0;
            bus.start_pc   <= 8'd0;
            bus.err        <= 1'b0;
            ptr            <= 8'd0;
            remaining      <= 8'd0;
            hi             <= 8'd0;
            sum            <= 8'd0;
        end else begin
            bus.ram_w_en  <= 1'b0;
            bus.cpu_rst_n <= (next_state == S_RUN);
            if (accept) begin
                case (state)
                    S_ADDR: begin
                        bus.start_pc <= bus.in_data;
                        ptr          <= bus.in_data;
                        sum          <= bus.in_data;
                    end
                    S_CNT: begin
                        remaining <= bus.in_data;
                        sum       <= sum + bus.in_data;
                    end
                    S_HI: begin
                        hi  <= bus.in_data;
                        sum <= sum + bus.in_data;
                    end
                    S_LO: begin
                        sum            <= sum + bus.in_data;
                        bus.ram_w_en   <= 1'b1;
                        bus.ram_w_addr <= ptr;
                        bus.ram_w_data <= {hi, bus.in_data};
                        ptr            <= ptr + 8'd1;
                        remaining      <= remaining - 8'd1;
                    end
                    S_CSUM:  bus.err <= (bus.in_data != sum);
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for the program loader with directed frames
module tb_prog_loader;
    typedef logic [7:0] byte_q_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   pulses = 0;
    logic [23:0] exp_q[$];

    prog_loader_if bus();
    prog_loader_if bus0();

    prog_loader #(.CHECKSUM_EN(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    prog_loader #(.CHECKSUM_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every write strobe is popped against the scoreboard
    always @(negedge clk) begin
        if (bus.ram_w_en === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) chk("unexpected_write", {8'd0, bus.ram_w_addr, bus.ram_w_data}, 32'hFFFF_FFFF);
            else chk("write", {8'd0, bus.ram_w_addr, bus.ram_w_data}, {8'd0, exp_q.pop_front()});
        end
        if (bus0.ram_w_en === 1'b1) chk("nocsum_write", 32'd1, 32'd0);
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 5)) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    task automatic send_frame(input byte_q_t f, input bit gaps);
        foreach (f[i]) send_byte(f[i], gaps);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_run(input string tag, input logic [7:0] pc);
        chk({tag, "_cpu_rst_n"}, {31'd0, bus.cpu_rst_n}, 32'd1);
        chk({tag, "_start_pc"},  {24'd0, bus.start_pc}, {24'd0, pc});
        chk({tag, "_bus_own"},   {31'd0, bus.bus_own}, 32'd0);
        chk({tag, "_err"},       {31'd0, bus.err}, 32'd0);
        chk({tag, "_in_ready"},  {31'd0, bus.in_ready}, 32'd0);
        chk({tag, "_queue"},     exp_q.size(), 32'd0);
    endtask

    initial begin
        byte_q_t f1, fw, fbad, fe;
        int p0;
        f1   = '{8'h10, 8'h02, 8'hC0, 8'h05, 8'hE0, 8'h00, 8'hB7};
        fw   = '{8'hFF, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h15};
        fbad = '{8'h10, 8'h02, 8'hC0, 8'h05, 8'hE0, 8'h00, 8'hB8};
        fe   = '{8'h40, 8'h00, 8'h40};
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'd0;
        bus0.in_valid = 1'b0;
        bus0.in_data  = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_ram_w_en",  {31'd0, bus.ram_w_en}, 32'd0);
        chk("rst_cpu_rst_n", {31'd0, bus.cpu_rst_n}, 32'd0);
        chk("rst_start_pc",  {24'd0, bus.start_pc}, 32'd0);
        chk("rst_err",       {31'd0, bus.err}, 32'd0);
        chk("rst_bus_own",   {31'd0, bus.bus_own}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("idle_ram_addr", {24'd0, bus.ram_w_addr}, 32'd0);

        p0 = pulses;
        exp_q.push_back({8'h10, 16'hC005});
        exp_q.push_back({8'h11, 16'hE000});
        send_frame(f1, 1'b0);
        chk("f1_pulses", pulses - p0, 32'd2);
        chk_run("f1", 8'h10);
        repeat (3) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("run_garbage_pulses", pulses - p0, 32'd2);
        chk_run("run_garbage", 8'h10);

        do_reset();
        exp_q.push_back({8'hFF, 16'h1234});
        exp_q.push_back({8'h00, 16'h5678});
        send_frame(fw, 1'b0);
        chk_run("wrap", 8'hFF);

        do_reset();
        p0 = pulses;
        exp_q.push_back({8'h10, 16'hC005});
        exp_q.push_back({8'h11, 16'hE000});
        send_frame(fbad, 1'b0);
        repeat (5) @(negedge clk);
        chk("bad_pulses",    pulses - p0, 32'd2);
        chk("bad_err",       {31'd0, bus.err}, 32'd1);
        chk("bad_cpu_rst_n", {31'd0, bus.cpu_rst_n}, 32'd0);
        chk("bad_in_ready",  {31'd0, bus.in_ready}, 32'd0);
        chk("bad_bus_own",   {31'd0, bus.bus_own}, 32'd1);
        do_reset();
        chk("bad_err_cleared", {31'd0, bus.err}, 32'd0);

        p0 = pulses;
        send_frame(fe, 1'b0);
        chk("empty_pulses", pulses - p0, 32'd0);
        chk_run("empty", 8'h40);

        do_reset();
        p0 = pulses;
        exp_q.push_back({8'h10, 16'hC005});
        exp_q.push_back({8'h11, 16'hE000});
        send_frame(f1, 1'b1);
        chk("gap_pulses", pulses - p0, 32'd2);
        chk_run("gap", 8'h10);

        do_reset();
        p0 = pulses;
        send_byte(8'h10, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'hC0, 1'b0);
        #2 bus.in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("mid_start_pc",  {24'd0, bus.start_pc}, 32'd0);
        chk("mid_cpu_rst_n", {31'd0, bus.cpu_rst_n}, 32'd0);
        chk("mid_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        chk("mid_ram_w_en",  {31'd0, bus.ram_w_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_pulses", pulses - p0, 32'd0);
        exp_q.push_back({8'h10, 16'hC005});
        exp_q.push_back({8'h11, 16'hE000});
        send_frame(f1, 1'b0);
        chk_run("after_mid", 8'h10);

        do_reset();
        @(negedge clk);
        bus0.in_valid = 1'b1;
        bus0.in_data  = 8'h40;
        @(negedge clk);
        bus0.in_data  = 8'h00;
        chk("nocsum_cnt_ready", {31'd0, bus0.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("nocsum_cpu_rst_n", {31'd0, bus0.cpu_rst_n}, 32'd1);
        chk("nocsum_in_ready",  {31'd0, bus0.in_ready}, 32'd0);
        chk("nocsum_start_pc",  {24'd0, bus0.start_pc}, 32'h40);
        bus0.in_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
